// File: rtl/data_reshuffler_ctrl_pkg.sv
// Shared types and constants for the data_reshuffler_ctrl sequencer.
package data_reshuffler_ctrl_pkg;

  localparam int unsigned DefaultCntWidth   = 32;
  localparam int unsigned TransposeCsrWidth = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/reshuffler_beat_counter.sv
// Saturating beat counter: synchronous clear, counts enabled beats up to i_limit and holds there.
module reshuffler_beat_counter #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic [CntWidth-1:0] i_limit,
  output logic [CntWidth-1:0] o_count,
  output logic                o_at_limit
);

  logic [CntWidth-1:0] r_count;
  logic                w_at_limit;

  assign w_at_limit = (r_count >= i_limit);
  assign o_count    = r_count;
  assign o_at_limit = w_at_limit;

  // Count register: clear wins, then increment only while below the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !w_at_limit) begin
      r_count <= r_count + CntWidth'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/data_reshuffler_ctrl.sv
// Sequencer in front of data_reshuffler: accepts one CSR job, configures the reshuffler and meters num_tiles beats.
// Stall counters on the perf ports are built only when DATA_RESHUFFLER_CTRL_PERF_EN is defined.
module data_reshuffler_ctrl
  import data_reshuffler_ctrl_pkg::*;
#(
  parameter int unsigned SpatPar   = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = DefaultCntWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [TransposeCsrWidth-1:0]   csr_transpose_i,
  input  logic [CntWidth-1:0]            csr_num_tiles_i,
  input  logic                           csr_valid_i,
  output logic                           csr_ready_o,
  output logic                           busy_o,
  output logic                           done_o,
  input  logic [SpatPar*DataWidth-1:0]   in_data_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic [SpatPar*DataWidth-1:0]   rs_a_o,
  output logic                           rs_a_valid_o,
  input  logic                           rs_a_ready_i,
  output logic [TransposeCsrWidth-1:0]   rs_csr_o,
  output logic                           rs_csr_valid_o,
  input  logic                           rs_csr_ready_i,
  input  logic                           rs_z_valid_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           rs_z_ready_o,
  output logic [CntWidth-1:0]            perf_in_stall_o,
  output logic [CntWidth-1:0]            perf_out_stall_o
);

  ctrl_state_e                  r_state;
  ctrl_state_e                  w_state_next;
  logic [TransposeCsrWidth-1:0] r_tr;
  logic [CntWidth-1:0]          r_num;

  logic                w_accept;
  logic                w_in_fire;
  logic                w_in_last;
  logic                w_out_fire;
  logic                w_out_last;
  logic [CntWidth-1:0] w_in_cnt;
  logic [CntWidth-1:0] w_out_cnt;
  logic                w_in_at_limit;
  logic                w_out_at_limit;

  assign w_accept   = (r_state == IDLE) && csr_valid_i;
  assign w_in_fire  = (r_state == RUN) && in_valid_i && rs_a_ready_i && !w_in_at_limit;
  assign w_in_last  = w_in_fire && ((w_in_cnt + CntWidth'(1)) == r_num);
  // Outputs are only metered while a job is streaming; stray beats elsewhere are ignored.
  assign w_out_fire = ((r_state == RUN) || (r_state == DRAIN)) && rs_z_valid_i && out_ready_i;
  assign w_out_last = w_out_fire && !w_out_at_limit && ((w_out_cnt + CntWidth'(1)) == r_num);

  assign rs_a_o       = in_data_i;
  assign out_valid_o  = rs_z_valid_i;
  assign rs_z_ready_o = out_ready_i;

  reshuffler_beat_counter #(.CntWidth(CntWidth)) u_in_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_clear    (w_accept),
    .i_en       (w_in_fire),
    .i_limit    (r_num),
    .o_count    (w_in_cnt),
    .o_at_limit (w_in_at_limit)
  );

  reshuffler_beat_counter #(.CntWidth(CntWidth)) u_out_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_clear    (w_accept),
    .i_en       (w_out_fire),
    .i_limit    (r_num),
    .o_count    (w_out_cnt),
    .o_at_limit (w_out_at_limit)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Job registers, loaded only when a job is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tr  <= '0;
      r_num <= '0;
    end else if (w_accept) begin
      r_tr  <= csr_transpose_i;
      r_num <= csr_num_tiles_i;
    end else begin
      r_tr  <= r_tr;
      r_num <= r_num;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next   = r_state;
    csr_ready_o    = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    rs_csr_valid_o = 1'b0;
    rs_csr_o       = '0;
    rs_a_valid_o   = 1'b0;
    in_ready_o     = 1'b0;
    case (r_state)
      IDLE: begin
        csr_ready_o = 1'b1;
        if (csr_valid_i) w_state_next = CFG;
        else             w_state_next = IDLE;
      end
      CFG: begin
        busy_o         = 1'b1;
        rs_csr_valid_o = 1'b1;
        rs_csr_o       = r_tr;
        if (rs_csr_ready_i) begin
          if (r_num == '0) w_state_next = DONE;
          else             w_state_next = RUN;
        end else begin
          w_state_next = CFG;
        end
      end
      RUN: begin
        busy_o       = 1'b1;
        rs_a_valid_o = in_valid_i && !w_in_at_limit;
        in_ready_o   = rs_a_ready_i && !w_in_at_limit;
        if (w_in_last) w_state_next = DRAIN;
        else           w_state_next = RUN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (w_out_at_limit || w_out_last) w_state_next = DONE;
        else                              w_state_next = DRAIN;
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef DATA_RESHUFFLER_CTRL_PERF_EN
  logic [CntWidth-1:0] r_perf_in;
  logic [CntWidth-1:0] r_perf_out;
  logic                w_in_stall;
  logic                w_out_stall;

  assign w_in_stall  = (r_state == RUN) && in_valid_i && !rs_a_ready_i;
  assign w_out_stall = ((r_state == RUN) || (r_state == DRAIN)) && rs_z_valid_i && !out_ready_i;

  // Stall counters: cleared per job, saturate at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_in  <= '0;
      r_perf_out <= '0;
    end else if (w_accept) begin
      r_perf_in  <= '0;
      r_perf_out <= '0;
    end else begin
      if (w_in_stall && (r_perf_in != '1)) r_perf_in <= r_perf_in + CntWidth'(1);
      else                                 r_perf_in <= r_perf_in;
      if (w_out_stall && (r_perf_out != '1)) r_perf_out <= r_perf_out + CntWidth'(1);
      else                                   r_perf_out <= r_perf_out;
    end
  end

  assign perf_in_stall_o  = r_perf_in;
  assign perf_out_stall_o = r_perf_out;
`else
  assign perf_in_stall_o  = '0;
  assign perf_out_stall_o = '0;
`endif

endmodule

// File: tb/tb_data_reshuffler_ctrl.sv
// Self-checking bench for data_reshuffler_ctrl: job table, random jobs against a timestamp-based model, abort sequence.
module tb_data_reshuffler_ctrl;

  localparam int SP = 8;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int BW = SP * DW;

`ifdef DATA_RESHUFFLER_CTRL_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [31:0]   csr_transpose_i;
  logic [CW-1:0] csr_num_tiles_i;
  logic          csr_valid_i;
  logic          csr_ready_o;
  logic          busy_o;
  logic          done_o;
  logic [BW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [BW-1:0] rs_a_o;
  logic          rs_a_valid_o;
  logic          rs_a_ready_i;
  logic [31:0]   rs_csr_o;
  logic          rs_csr_valid_o;
  logic          rs_csr_ready_i;
  logic          rs_z_valid_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          rs_z_ready_o;
  logic [CW-1:0] perf_in_stall_o;
  logic [CW-1:0] perf_out_stall_o;

  always #5 clk_i = ~clk_i;

  data_reshuffler_ctrl #(.SpatPar(SP), .DataWidth(DW), .CntWidth(CW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .csr_transpose_i  (csr_transpose_i),
    .csr_num_tiles_i  (csr_num_tiles_i),
    .csr_valid_i      (csr_valid_i),
    .csr_ready_o      (csr_ready_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .in_data_i        (in_data_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .rs_a_o           (rs_a_o),
    .rs_a_valid_o     (rs_a_valid_o),
    .rs_a_ready_i     (rs_a_ready_i),
    .rs_csr_o         (rs_csr_o),
    .rs_csr_valid_o   (rs_csr_valid_o),
    .rs_csr_ready_i   (rs_csr_ready_i),
    .rs_z_valid_i     (rs_z_valid_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .rs_z_ready_o     (rs_z_ready_o),
    .perf_in_stall_o  (perf_in_stall_o),
    .perf_out_stall_o (perf_out_stall_o)
  );

  int errs = 0;
  int checks = 0;
  int pending = 0;  // beats held inside the emulated 1-cycle reshuffler

  typedef struct {
    logic [31:0] tr;
    int          num;
    int          p_valid;
    int          p_aready;
    int          p_csrrdy;
    int          p_outrdy;
    int          out_stall;
    bit          noise;
    int          exp_in;
    int          exp_gap;
    int          exp_pout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit chance(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic drive_idle();
    csr_valid_i     = 1'b0;
    csr_transpose_i = '0;
    csr_num_tiles_i = '0;
    in_valid_i      = 1'b0;
    in_data_i       = '0;
    rs_a_ready_i    = 1'b0;
    rs_csr_ready_i  = 1'b0;
    rs_z_valid_i    = 1'b0;
    out_ready_i     = 1'b0;
  endtask

  // Runs one job starting at the accept cycle (t=0). The model works from timestamps:
  // cfg_end = CSR handshake cycle, m = last input fire, k = last counted output, d = done cycle.
  task automatic run_job(input logic [31:0] tr, input int num, input int p_valid, input int p_aready,
                         input int p_csrrdy, input int p_outrdy, input int out_stall, input bit noise,
                         output int dut_in, output int dut_gap, output int dut_pout);
    int cfg_end = -1, m = -1, k = -1, d = -1;
    int n_in = 0, nout = 0, m_in = 0, m_out = 0;
    int dut_last = 0, dut_done = -1;
    bit cfg_w, run_w, out_w, a_fire, z_fire, finished;
    finished = 1'b0;
    dut_in = 0;
    for (int t = 0; t < 800; t++) begin
      if (t == 0) begin
        csr_valid_i = 1'b1; csr_transpose_i = tr; csr_num_tiles_i = CW'(num);
      end else if (noise && (d < 0 || t <= d)) begin
        csr_valid_i = chance(50); csr_transpose_i = $urandom(); csr_num_tiles_i = CW'($urandom_range(0, 20));
      end else begin
        csr_valid_i = 1'b0;
      end
      in_valid_i = chance(p_valid);
      for (int i = 0; i < BW / 32; i++) in_data_i[i*32 +: 32] = $urandom();
      rs_a_ready_i   = chance(p_aready);
      rs_csr_ready_i = chance(p_csrrdy);
      out_ready_i    = (m >= 0 && t > m && t <= m + out_stall) ? 1'b0 : chance(p_outrdy);
      rs_z_valid_i   = (pending > 0);
      #3;
      cfg_w = (t >= 1) && (cfg_end < 0);
      run_w = (num > 0) && (cfg_end >= 0) && (t > cfg_end) && (m < 0);
      out_w = (num > 0) && (cfg_end >= 0) && (t > cfg_end) && (d < 0 || t < d);
      check("csr_ready", 64'(csr_ready_o), 64'(!((t >= 1) && (d < 0 || t <= d))));
      check("busy", 64'(busy_o), 64'((t >= 1) && (d < 0 || t < d)));
      check("done", 64'(done_o), 64'((d >= 0) && (t == d)));
      check("rs_csr_valid", 64'(rs_csr_valid_o), 64'(cfg_w));
      if (cfg_w) check("rs_csr", 64'(rs_csr_o), 64'(tr));
      check("rs_a_valid", 64'(rs_a_valid_o), 64'(run_w && in_valid_i));
      check("in_ready", 64'(in_ready_o), 64'(run_w && rs_a_ready_i));
      if (run_w) check("rs_a_data", 64'(rs_a_o == in_data_i), 64'd1);
      check("out_valid", 64'(out_valid_o), 64'(rs_z_valid_i));
      check("rs_z_ready", 64'(rs_z_ready_o), 64'(out_ready_i));
      if (t >= 1) begin
        check("perf_in", 64'(perf_in_stall_o), PerfOn ? 64'(m_in) : 64'd0);
        check("perf_out", 64'(perf_out_stall_o), PerfOn ? 64'(m_out) : 64'd0);
      end
      if (in_valid_i && in_ready_o) begin dut_in++; dut_last = t; end
      if (done_o && dut_done < 0) dut_done = t;
      if (d >= 0 && t == d + 1) begin finished = 1'b1; break; end
      if (cfg_w && rs_csr_ready_i) begin cfg_end = t; if (num == 0) d = t + 1; end
      a_fire = run_w && in_valid_i && rs_a_ready_i;
      z_fire = rs_z_valid_i && out_ready_i;
      if (run_w && in_valid_i && !rs_a_ready_i) m_in++;
      if (out_w && rs_z_valid_i && !out_ready_i) m_out++;
      if (a_fire) begin n_in++; if (n_in == num) m = t; end
      if (out_w && z_fire && nout < num) begin nout++; if (nout == num) k = t; end
      if (a_fire) pending++;
      if (z_fire && pending > 0) pending--;
      if (d < 0 && m >= 0 && nout == num) d = ((m + 1 > k) ? m + 1 : k) + 1;
      @(posedge clk_i); #1;
    end
    csr_valid_i = 1'b0;
    in_valid_i  = 1'b0;
    rs_z_valid_i = 1'b0;
    checks++;
    if (!finished) begin
      errs++;
      $display("FAIL job_timeout: job of %0d tiles did not complete within the cycle budget", num);
      rst_ni = 1'b0; pending = 0; #2; rst_ni = 1'b1;
      @(posedge clk_i); #1;
    end
    dut_gap  = (dut_done < 0) ? -1 : ((num == 0) ? dut_done : dut_done - dut_last);
    dut_pout = int'(perf_out_stall_o);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int got_in, got_gap, got_pout;
    vecs[0] = '{32'h0000_0001, 4, 100, 100, 100, 100, 0, 1'b0, 4, 2, 0};
    vecs[1] = '{32'h0000_0007, 0, 100, 100, 100, 100, 0, 1'b0, 0, 2, 0};
    vecs[2] = '{32'h0000_0000, 3, 100, 100, 100, 100, 0, 1'b0, 3, 2, 0};
    vecs[3] = '{32'h8000_0000, 4, 100, 100, 100, 100, 5, 1'b0, 4, 7, PerfOn ? 5 : 0};
    vecs[4] = '{32'h0000_0002, 6, 100, 100, 100, 100, 0, 1'b1, 6, 2, 0};

    // Reset state with every input pushing to be active.
    drive_idle();
    rst_ni = 1'b0;
    in_valid_i = 1'b1; rs_a_ready_i = 1'b1; rs_csr_ready_i = 1'b1;
    rs_z_valid_i = 1'b1; out_ready_i = 1'b0;
    #3;
    check("rst_csr_ready", 64'(csr_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rs_csr_valid", 64'(rs_csr_valid_o), 64'd0);
    check("rst_rs_a_valid", 64'(rs_a_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_perf_in", 64'(perf_in_stall_o), 64'd0);
    check("rst_perf_out", 64'(perf_out_stall_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd1);
    repeat (3) @(posedge clk_i);
    #1;
    drive_idle();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].tr, vecs[v].num, vecs[v].p_valid, vecs[v].p_aready, vecs[v].p_csrrdy,
              vecs[v].p_outrdy, vecs[v].out_stall, vecs[v].noise, got_in, got_gap, got_pout);
      check($sformatf("vec%0d_beats_in", v), 64'(got_in), 64'(vecs[v].exp_in));
      check($sformatf("vec%0d_done_gap", v), 64'(got_gap), 64'(vecs[v].exp_gap));
      check($sformatf("vec%0d_perf_out", v), 64'(got_pout), 64'(vecs[v].exp_pout));
    end

    // Abort: reset asserted mid-RUN after 2 of 8 beats.
    csr_valid_i = 1'b1; csr_transpose_i = 32'h3; csr_num_tiles_i = CW'(8);
    rs_csr_ready_i = 1'b1; rs_a_ready_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    csr_valid_i = 1'b0;
    @(posedge clk_i); #1;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    #2;
    check("abort_busy_before", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_csr_ready", 64'(csr_ready_o), 64'd1);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_rs_csr_valid", 64'(rs_csr_valid_o), 64'd0);
    check("abort_perf_in", 64'(perf_in_stall_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("abort_no_done", 64'(done_o), 64'd0);
    end
    drive_idle();
    pending = 0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_job(32'h1, 2, 100, 100, 100, 100, 0, 1'b0, got_in, got_gap, got_pout);
    check("after_abort_beats_in", 64'(got_in), 64'd2);
    check("after_abort_done_gap", 64'(got_gap), 64'd2);

    // Random jobs against the model.
    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(40, 100), $urandom_range(40, 100),
              $urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              got_in, got_gap, got_pout);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
